// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the memory port arbiter.
// Legal parameter ranges, index-width helper, response-pipeline entry.
package mem_arb_pkg;

  localparam int MAX_PORTS        = 8;
  localparam int MAX_READ_LATENCY = 4;
  localparam int MAX_INDEX_WIDTH  = 3;

  function automatic int PORT_INDEX_WIDTH(input int num_ports);
    return (num_ports <= 1) ? 1 : $clog2(num_ports);
  endfunction

  typedef struct packed {
    logic                       valid;
    logic [MAX_INDEX_WIDTH-1:0] port;
  } resp_entry_t;

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or above ptr_i.
// Pure function of its inputs so it can be reused for interrupt selection.
module rr_picker #(
  parameter int NUM_PORTS   = 2,
  parameter int INDEX_WIDTH = 1
) (
  input  logic [NUM_PORTS-1:0]   req_i,
  input  logic [INDEX_WIDTH-1:0] ptr_i,
  output logic [NUM_PORTS-1:0]   grant_o,
  output logic [INDEX_WIDTH-1:0] index_o,
  output logic                   any_o
);

  logic [2*NUM_PORTS-1:0] rot;

  assign rot = {req_i, req_i} >> ptr_i;

  // Rotate so the pointer sits at bit 0, take the lowest set bit, unrotate.
  always_comb begin
    int sum;
    grant_o = '0;
    index_o = '0;
    any_o   = 1'b0;
    sum     = 0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!any_o && rot[j]) begin
        any_o = 1'b1;
        sum   = int'(ptr_i) + j;
        if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
        index_o = INDEX_WIDTH'(sum);
        grant_o = NUM_PORTS'(1) << index_o;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter merging requesters onto one single-port memory.
// Define MEM_ARB_LOCK_EN to add req_lock for atomic read-modify-write.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int NUM_PORTS    = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             req_valid,
  output logic [NUM_PORTS-1:0]             req_ready,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_write_data,
`ifdef MEM_ARB_LOCK_EN
  input  logic [NUM_PORTS-1:0]             req_lock,
`endif
  output logic [NUM_PORTS-1:0]             resp_valid,
  output logic [DATA_WIDTH-1:0]            resp_read_data,
  output logic                             mem_write_enable,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  output logic [DATA_WIDTH-1:0]            mem_write_data,
  input  logic [DATA_WIDTH-1:0]            mem_read_data
);

  localparam int IW = PORT_INDEX_WIDTH(NUM_PORTS);

  if (NUM_PORTS < 1 || NUM_PORTS > MAX_PORTS) begin : g_bad_ports
    $error("NUM_PORTS out of range");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_lat
    $error("READ_LATENCY out of range");
  end

  logic [IW-1:0]        ptr_q, ptr_d;
  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] grant;
  logic [IW-1:0]        gidx;
  logic                 any;
  logic                 accept;
  resp_entry_t          push;
  resp_entry_t          tail;
  resp_entry_t          pipe_q [READ_LATENCY];

`ifdef MEM_ARB_LOCK_EN
  logic          lock_q, lock_d;
  logic [IW-1:0] lock_port_q, lock_port_d;

  // While locked only the owning port may compete.
  always_comb begin
    eligible = req_valid;
    if (lock_q) eligible = req_valid & (NUM_PORTS'(1) << lock_port_q);
  end

  // Every acceptance re-evaluates the lock from that port's req_lock.
  always_comb begin
    lock_d      = lock_q;
    lock_port_d = lock_port_q;
    if (accept) begin
      lock_d      = req_lock[gidx];
      lock_port_d = gidx;
    end
  end

  // Lock state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_q      <= 1'b0;
      lock_port_q <= '0;
    end else begin
      lock_q      <= lock_d;
      lock_port_q <= lock_port_d;
    end
  end
`else
  assign eligible = req_valid;
`endif

  rr_picker #(
    .NUM_PORTS   (NUM_PORTS),
    .INDEX_WIDTH (IW)
  ) u_picker (
    .req_i   (eligible),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .index_o (gidx),
    .any_o   (any)
  );

  assign accept    = any & ~reset;
  assign req_ready = accept ? grant : '0;

  // Pointer moves just past the accepted port, wrapping at the top.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      if (int'(gidx) == NUM_PORTS - 1) ptr_d = '0;
      else                             ptr_d = gidx + 1'b1;
    end
  end

  // Memory side is driven from the granted port, zero when idle.
  always_comb begin
    mem_write_enable = 1'b0;
    mem_address      = '0;
    mem_write_data   = '0;
    if (accept) begin
      mem_write_enable = req_write[gidx];
      mem_address      = req_address[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
      mem_write_data   = req_write_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Only accepted reads travel down the response pipeline.
  always_comb begin
    push.valid = accept & ~req_write[gidx];
    push.port  = MAX_INDEX_WIDTH'(gidx);
  end

  // Pointer and response shift register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      ptr_q     <= ptr_d;
      pipe_q[0] <= push;
      for (int i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tail = pipe_q[READ_LATENCY-1];

  // Tail entry steers memory read data to its requester for one cycle.
  always_comb begin
    resp_valid     = '0;
    resp_read_data = '0;
    if (tail.valid) begin
      resp_valid     = NUM_PORTS'(1) << tail.port;
      resp_read_data = mem_read_data;
    end
  end

endmodule
